// File: rtl/core_pkg.sv
// Shared definitions for the fetch/next-PC controller: FSM states,
// next-PC select codes and the opcode/funct values the sequencer decodes.
package core_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [2:0] PC_SEL_SEQ    = 3'b000;
   localparam logic [2:0] PC_SEL_JUMP   = 3'b001;
   localparam logic [2:0] PC_SEL_REG    = 3'b010;
   localparam logic [2:0] PC_SEL_BRANCH = 3'b011;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_HALT  = 6'b111111;
   localparam logic [5:0] FUNCT_JR = 6'b001000;

endpackage

// File: rtl/npc_select.sv
// Combinational next-PC source selection from the decoded instruction
// fields and the ALU zero flag reported with exec_done.
module npc_select
   import core_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   output logic [2:0] pc_sel
);

   // NOTE: assigning the default before the case keeps every path driven, so no latch is inferred.
   always_comb begin
      pc_sel = PC_SEL_SEQ;
      case (opcode)
         OP_J, OP_JAL: pc_sel = PC_SEL_JUMP;
         OP_RTYPE:     if (funct == FUNCT_JR) pc_sel = PC_SEL_REG;
         OP_BEQ:       if (alu_zero)          pc_sel = PC_SEL_BRANCH;
         OP_BNE:       if (!alu_zero)         pc_sel = PC_SEL_BRANCH;
         default:      ;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/update sequencer: fetches over a req/ack
// handshake, starts execute, and issues one pc_en pulse per retired instruction.
module pc_sequencer
   import core_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stall,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [31:0]      imem_data,
   output logic [31:0]      ir,
   output logic             exec_start,
   input  logic             exec_done,
   input  logic             alu_zero,
   output logic             pc_en,
   output logic [2:0]       pc_control,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] instr_count
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic              imem_req_q, imem_req_d;
   logic [31:0]       ir_q, ir_d;
   logic [2:0]        pc_control_q, pc_control_d;
   logic              halted_q, halted_d;
   logic              mem_err_q, mem_err_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0]  instr_count_q, instr_count_d;
   logic [2:0]        npc_sel;

   npc_select u_npc_select (
      .opcode   (ir_q[31:26]),
      .funct    (ir_q[5:0]),
      .alu_zero (alu_zero),
      .pc_sel   (npc_sel)
   );

   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      pc_control_d  = pc_control_q;
      halted_d      = halted_q;
      mem_err_d     = mem_err_q;
      to_cnt_d      = '0;
      instr_count_d = instr_count_q;
      exec_start    = 1'b0;
      pc_en         = 1'b0;

      case (state_q)
         ST_IDLE: if (start) state_d = ST_FETCH;
         ST_FETCH: begin
            to_cnt_d = to_cnt_q + 1'b1;
            // An ack arriving on the final allowed cycle still completes the fetch.
            if (imem_ack) begin
               ir_d     = imem_data;
               to_cnt_d = '0;
               state_d  = ST_DECODE;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               mem_err_d = 1'b1;
               halted_d  = 1'b1;
               to_cnt_d  = '0;
               state_d   = ST_HALT;
            end
         end
         ST_DECODE: begin
            if (ir_q[31:26] == OP_HALT) begin
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               exec_start = 1'b1;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               pc_control_d = npc_sel;
               state_d      = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            if (!stall) begin
               pc_en         = 1'b1;
               instr_count_d = instr_count_q + 1'b1;
               state_d       = ST_FETCH;
            end
         end
         ST_HALT: ;
         default: state_d = ST_IDLE;
      endcase

      // Request is registered so it is high for every cycle spent in FETCH.
      imem_req_d = (state_d == ST_FETCH);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         imem_req_q    <= 1'b0;
         ir_q          <= '0;
         pc_control_q  <= PC_SEL_SEQ;
         halted_q      <= 1'b0;
         mem_err_q     <= 1'b0;
         to_cnt_q      <= '0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         imem_req_q    <= imem_req_d;
         ir_q          <= ir_d;
         pc_control_q  <= pc_control_d;
         halted_q      <= halted_d;
         mem_err_q     <= mem_err_d;
         to_cnt_q      <= to_cnt_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign ir          = ir_q;
   assign pc_control  = pc_control_q;
   assign halted      = halted_q;
   assign mem_err     = mem_err_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with TIMEOUT=4; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_pc_sequencer;
   import core_pkg::*;

   localparam logic [31:0] I_ADDI = 32'h2001_0005;
   localparam logic [31:0] I_J    = 32'h0800_0010;
   localparam logic [31:0] I_JR   = 32'h03E0_0008;
   localparam logic [31:0] I_BEQ  = 32'h1022_0003;
   localparam logic [31:0] I_BNE  = 32'h1422_0003;
   localparam logic [31:0] I_HALT = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = '0;
   logic [31:0] ir;
   logic        exec_start;
   logic        exec_done = 1'b0;
   logic        alu_zero = 1'b0;
   logic        pc_en;
   logic [2:0]  pc_control;
   logic        halted;
   logic        mem_err;
   logic [31:0] instr_count;

   int          n_run = 0;
   int          n_fail = 0;
   logic [31:0] exp_count = '0;

   pc_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .ir          (ir),
      .exec_start  (exec_start),
      .exec_done   (exec_done),
      .alu_zero    (alu_zero),
      .pc_en       (pc_en),
      .pc_control  (pc_control),
      .halted      (halted),
      .mem_err     (mem_err),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_imem_req"},    32'(imem_req),   32'd0);
      check({tag, "_exec_start"},  32'(exec_start), 32'd0);
      check({tag, "_pc_en"},       32'(pc_en),      32'd0);
      check({tag, "_halted"},      32'(halted),     32'd0);
      check({tag, "_mem_err"},     32'(mem_err),    32'd0);
      check({tag, "_pc_control"},  32'(pc_control), 32'd0);
      check({tag, "_ir"},          ir,              32'd0);
      check({tag, "_instr_count"}, instr_count,     32'd0);
   endtask

   // Asserts reset without waiting for a clock edge, checks, then releases on a falling edge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check_zero(tag);
      @(negedge clk);
      rst_n     = 1'b1;
      exp_count = '0;
   endtask

   task automatic begin_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered during the first FETCH cycle; returns during the next first FETCH cycle.
   task automatic do_instr(input logic [31:0] instr, input logic zero, input int ack_delay,
                           input logic [2:0] exp_sel);
      for (int i = 0; i < ack_delay; i++) begin
         check("fetch_wait_req", 32'(imem_req), 32'd1);
         check("fetch_wait_err", 32'(mem_err),  32'd0);
         @(negedge clk);
      end
      check("fetch_req", 32'(imem_req), 32'd1);
      imem_ack  = 1'b1;
      imem_data = instr;
      @(negedge clk);
      imem_ack = 1'b0;
      check("decode_exec_start", 32'(exec_start), 32'd1);
      check("decode_ir",         ir,              instr);
      check("decode_req_drop",   32'(imem_req),   32'd0);
      check("decode_no_err",     32'(mem_err),    32'd0);
      @(negedge clk);
      check("exec_start_pulse", 32'(exec_start), 32'd0);
      exec_done = 1'b1;
      alu_zero  = zero;
      @(negedge clk);
      exec_done = 1'b0;
      check("update_pc_en",      32'(pc_en),      32'd1);
      check("update_pc_control", 32'(pc_control), 32'(exp_sel));
      @(negedge clk);
      exp_count++;
      check("pc_en_single",  32'(pc_en),    32'd0);
      check("instr_count",   instr_count,   exp_count);
      check("refetch_req",   32'(imem_req), 32'd1);
   endtask

   initial begin
      #2;
      do_reset("reset");
      @(negedge clk);
      check("idle_req", 32'(imem_req), 32'd0);
      imem_ack  = 1'b1;
      exec_done = 1'b1;
      imem_data = I_J;
      @(negedge clk);
      check("idle_ignore_ack_ir",  ir,               32'd0);
      check("idle_ignore_req",     32'(imem_req),    32'd0);
      check("idle_ignore_pc_en",   32'(pc_en),       32'd0);
      imem_ack  = 1'b0;
      exec_done = 1'b0;

      begin_run();
      do_instr(I_ADDI, 1'b0, 0, PC_SEL_SEQ);
      do_instr(I_J,    1'b0, 0, PC_SEL_JUMP);
      do_instr(I_JR,   1'b0, 0, PC_SEL_REG);
      do_instr(I_BEQ,  1'b1, 0, PC_SEL_BRANCH);
      do_instr(I_BEQ,  1'b0, 0, PC_SEL_SEQ);
      do_instr(I_BNE,  1'b0, 0, PC_SEL_BRANCH);
      do_instr(I_BNE,  1'b1, 0, PC_SEL_SEQ);

      // Stall raised in the same cycle UPDATE is entered and held three cycles.
      imem_ack  = 1'b1;
      imem_data = I_J;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      exec_done = 1'b1;
      stall     = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_pc_en",      32'(pc_en),      32'd0);
         check("stall_pc_control", 32'(pc_control), 32'(PC_SEL_JUMP));
         check("stall_req",        32'(imem_req),   32'd0);
         check("stall_count",      instr_count,     exp_count);
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      check("unstall_pc_en", 32'(pc_en), 32'd1);
      @(negedge clk);
      exp_count++;
      check("unstall_pc_en_single", 32'(pc_en),    32'd0);
      check("unstall_count",        instr_count,   exp_count);
      check("unstall_refetch",      32'(imem_req), 32'd1);

      // Ack on the last allowed fetch cycle completes normally.
      do_instr(I_ADDI, 1'b0, 3, PC_SEL_SEQ);

      // No ack: four FETCH cycles then timeout.
      for (int i = 0; i < 4; i++) begin
         check("to_wait_req",    32'(imem_req), 32'd1);
         check("to_wait_err",    32'(mem_err),  32'd0);
         check("to_wait_halted", 32'(halted),   32'd0);
         @(negedge clk);
      end
      check("to_mem_err", 32'(mem_err),  32'd1);
      check("to_halted",  32'(halted),   32'd1);
      check("to_req",     32'(imem_req), 32'd0);
      start    = 1'b1;
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("halt_hold_req",    32'(imem_req), 32'd0);
         check("halt_hold_pc_en",  32'(pc_en),    32'd0);
         check("halt_hold_halted", 32'(halted),   32'd1);
         check("halt_hold_err",    32'(mem_err),  32'd1);
         check("halt_hold_count",  instr_count,   exp_count);
      end
      start    = 1'b0;
      imem_ack = 1'b0;

      // HALT opcode after one retired instruction.
      do_reset("reset_before_halt");
      begin_run();
      do_instr(I_ADDI, 1'b0, 0, PC_SEL_SEQ);
      imem_ack  = 1'b1;
      imem_data = I_HALT;
      @(negedge clk);
      imem_ack = 1'b0;
      check("hop_no_exec_start", 32'(exec_start), 32'd0);
      @(negedge clk);
      check("hop_halted",  32'(halted),   32'd1);
      check("hop_no_err",  32'(mem_err),  32'd0);
      check("hop_req",     32'(imem_req), 32'd0);
      exec_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hop_hold_req",   32'(imem_req), 32'd0);
         check("hop_hold_pc_en", 32'(pc_en),    32'd0);
         check("hop_hold_count", instr_count,   32'd1);
      end
      exec_done = 1'b0;

      // Asynchronous reset in the middle of EXEC.
      do_reset("reset_before_async");
      begin_run();
      do_instr(I_J, 1'b0, 0, PC_SEL_JUMP);
      imem_ack  = 1'b1;
      imem_data = I_BEQ;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      check("pre_rst_exec_ir", ir, I_BEQ);
      #2;
      do_reset("rst_mid_exec");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("post_rst_idle_req", 32'(imem_req), 32'd0);
      end

      // Asynchronous reset in the middle of FETCH.
      begin_run();
      check("pre_rst_fetch_req", 32'(imem_req), 32'd1);
      #2;
      do_reset("rst_mid_fetch");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("post_rst2_idle_req",    32'(imem_req), 32'd0);
         check("post_rst2_idle_halted", 32'(halted),   32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
